// File: rtl/parallel_bus_fifo_bridge.sv
// parallel_bus_fifo_bridge: host parallel-port bridge with an RX FIFO for host writes and a TX FIFO for host reads
// Ports:
//   clock, reset_n         system clock, async active-low reset
//   chip_select, strobe    host direction (1 = host writes) and word strobe (falling edge = transfer), async
//   data_pins              bidirectional host bus, driven only while bus_drive is high
//   rx_data/valid/ready    RX stream out of the FIFO holding host-written words
//   tx_data/valid/ready    TX stream into the FIFO feeding host reads
//   rx_level, tx_level     FIFO occupancies
//   rx_overflow            sticky: host write dropped because RX was full
//   tx_underrun            sticky: host read served IDLE_WORD because TX was empty
//   clear_flags            synchronous clear of both sticky flags (a same-cycle set wins)
//   bus_drive              high while the FPGA drives data_pins
module parallel_bus_fifo_bridge #(
    parameter int WIDTH = 8,
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16,
    parameter int SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] IDLE_WORD = '0
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        chip_select,
    input  logic                        strobe,
    inout  wire  [WIDTH-1:0]            data_pins,
    output logic [WIDTH-1:0]            rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    input  logic [WIDTH-1:0]            tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic [$clog2(RX_DEPTH):0]   rx_level,
    output logic [$clog2(TX_DEPTH):0]   tx_level,
    output logic                        rx_overflow,
    output logic                        tx_underrun,
    input  logic                        clear_flags,
    output logic                        bus_drive
);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int TAW = $clog2(TX_DEPTH);

    logic [SYNC_STAGES-1:0] cs_sync, stb_sync;
    logic [WIDTH-1:0]       pins_sync [SYNC_STAGES];
    logic                   cs_s, stb_s, stb_d, fall, host_wr, host_rd;
    logic [WIDTH-1:0]       pins_s, out_reg;

    logic [WIDTH-1:0] rx_mem [RX_DEPTH];
    logic [RAW-1:0]   rx_wp, rx_rp;
    logic             rx_full, rx_push, rx_pop;

    logic [WIDTH-1:0] tx_mem [TX_DEPTH];
    logic [TAW-1:0]   tx_wp, tx_rp;
    logic             tx_empty, tx_push, tx_pop;

    assign cs_s    = cs_sync[SYNC_STAGES-1];
    assign stb_s   = stb_sync[SYNC_STAGES-1];
    assign pins_s  = pins_sync[SYNC_STAGES-1];
    assign fall    = stb_d & ~stb_s;
    assign host_wr = fall & cs_s;
    assign host_rd = fall & ~cs_s;

    // Drive enable comes from a flop so the bus is released at reset and never follows the raw pin.
    assign data_pins = bus_drive ? out_reg : {WIDTH{1'bz}};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cs_sync   <= '0;
            stb_sync  <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) pins_sync[i] <= '0;
            stb_d     <= 1'b1;
            bus_drive <= 1'b0;
        end else begin
            cs_sync      <= {cs_sync[SYNC_STAGES-2:0], chip_select};
            stb_sync     <= {stb_sync[SYNC_STAGES-2:0], strobe};
            pins_sync[0] <= data_pins;
            for (int i = 1; i < SYNC_STAGES; i++) pins_sync[i] <= pins_sync[i-1];
            stb_d        <= stb_s;
            bus_drive    <= ~cs_s;
        end
    end

    // RX FIFO: a pop in the same cycle frees the slot, so a write at full is still accepted.
    assign rx_valid = rx_level != '0;
    assign rx_full  = rx_level == (RAW+1)'(RX_DEPTH);
    assign rx_pop   = rx_valid & rx_ready;
    assign rx_push  = host_wr & (~rx_full | rx_pop);
    assign rx_data  = rx_mem[rx_rp];

    always_ff @(posedge clock) if (rx_push) rx_mem[rx_wp] <= pins_s;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_wp       <= '0;
            rx_rp       <= '0;
            rx_level    <= '0;
            rx_overflow <= 1'b0;
        end else begin
            rx_wp       <= rx_push ? rx_wp + RAW'(1) : rx_wp;
            rx_rp       <= rx_pop ? rx_rp + RAW'(1) : rx_rp;
            rx_level    <= rx_level + (RAW+1)'(rx_push) - (RAW+1)'(rx_pop);
            rx_overflow <= (host_wr & ~rx_push) | (rx_overflow & ~clear_flags);
        end
    end

    // TX FIFO: push gated by tx_ready, so a full FIFO never accepts even while popping.
    assign tx_empty = tx_level == '0;
    assign tx_ready = tx_level != (TAW+1)'(TX_DEPTH);
    assign tx_push  = tx_valid & tx_ready;
    assign tx_pop   = host_rd & ~tx_empty;

    always_ff @(posedge clock) if (tx_push) tx_mem[tx_wp] <= tx_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_wp       <= '0;
            tx_rp       <= '0;
            tx_level    <= '0;
            tx_underrun <= 1'b0;
            out_reg     <= IDLE_WORD;
        end else begin
            tx_wp       <= tx_push ? tx_wp + TAW'(1) : tx_wp;
            tx_rp       <= tx_pop ? tx_rp + TAW'(1) : tx_rp;
            tx_level    <= tx_level + (TAW+1)'(tx_push) - (TAW+1)'(tx_pop);
            tx_underrun <= (host_rd & tx_empty) | (tx_underrun & ~clear_flags);
            out_reg     <= host_rd ? (tx_pop ? tx_mem[tx_rp] : IDLE_WORD) : out_reg;
        end
    end
endmodule

// File: tb/tb_parallel_bus_fifo_bridge.sv
// tb_parallel_bus_fifo_bridge: randomized host/stream traffic checked against a queue-based model
module tb_parallel_bus_fifo_bridge;
    logic       clock = 1'b0, reset_n = 1'b0, chip_select = 1'b1, strobe = 1'b1;
    logic       rx_ready = 1'b0, tx_valid = 1'b0, clear_flags = 1'b0, host_drive = 1'b0;
    logic [7:0] host_data = '0, tx_data = '0, rx_data, r;
    logic [4:0] rx_level, tx_level;
    logic       rx_valid, tx_ready, rx_overflow, tx_underrun, bus_drive;
    wire  [7:0] data_pins;

    int checks = 0, errors = 0;
    logic [7:0] rxq[$], txq[$];
    logic       m_ovf = 0, m_und = 0;
    logic [7:0] m_out = 8'h00;

    assign data_pins = host_drive ? host_data : 8'bz;
    always #5 clock = ~clock;

    parallel_bus_fifo_bridge dut (
        .clock(clock), .reset_n(reset_n), .chip_select(chip_select), .strobe(strobe),
        .data_pins(data_pins), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_level(rx_level),
        .tx_level(tx_level), .rx_overflow(rx_overflow), .tx_underrun(tx_underrun),
        .clear_flags(clear_flags), .bus_drive(bus_drive)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check_state(input string tag);
        check({tag, ".rx_level"}, rx_level, rxq.size());
        check({tag, ".tx_level"}, tx_level, txq.size());
        check({tag, ".rx_valid"}, rx_valid, rxq.size() != 0);
        check({tag, ".tx_ready"}, tx_ready, txq.size() < 16);
        check({tag, ".rx_overflow"}, rx_overflow, m_ovf);
        check({tag, ".tx_underrun"}, tx_underrun, m_und);
    endtask

    task automatic set_cs(input logic v);
        if (chip_select != v) begin
            if (!v) host_drive = 1'b0;
            chip_select = v;
            cyc(8);
            if (v) host_drive = 1'b1;
        end
    endtask

    task automatic host_write(input logic [7:0] w);
        set_cs(1'b1);
        host_data = w;
        cyc(6);
        strobe = 1'b0;
        cyc(6);
        strobe = 1'b1;
        cyc(6);
        if (rxq.size() < 16) rxq.push_back(w);
        else m_ovf = 1'b1;
    endtask

    task automatic host_read(input string tag);
        set_cs(1'b0);
        strobe = 1'b0;
        cyc(6);
        r = data_pins;
        strobe = 1'b1;
        cyc(6);
        if (txq.size() != 0) m_out = txq.pop_front();
        else begin
            m_out = 8'h00;
            m_und = 1'b1;
        end
        check(tag, r, m_out);
    endtask

    task automatic rx_pop(input string tag);
        check({tag, ".valid"}, rx_valid, 1);
        check({tag, ".data"}, rx_data, rxq[0]);
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
        void'(rxq.pop_front());
    endtask

    task automatic tx_push(input logic [7:0] d);
        tx_data = d;
        tx_valid = 1'b1;
        check("tx_push.ready", tx_ready, txq.size() < 16);
        cyc(1);
        tx_valid = 1'b0;
        if (txq.size() < 16) txq.push_back(d);
    endtask

    task automatic clear_pulse();
        clear_flags = 1'b1;
        cyc(1);
        clear_flags = 1'b0;
        m_ovf = 1'b0;
        m_und = 1'b0;
    endtask

    initial begin
        cyc(2);
        check_state("reset");
        check("reset.bus_drive", bus_drive, 0);
        reset_n = 1'b1;
        cyc(8);
        host_drive = 1'b1;
        check("idle.bus_drive", bus_drive, 0);

        // Three host writes arrive in order.
        host_write(8'h11);
        host_write(8'h22);
        host_write(8'h33);
        check_state("t1");
        for (int i = 0; i < 3; i++) rx_pop("t1.pop");

        // Fill RX, one extra write is dropped.
        for (int i = 0; i < 17; i++) host_write(8'(i * 7 + 3));
        check_state("t2.full");
        clear_pulse();
        check_state("t2.clear");

        // Write at full with a pop on the same cycle: accepted, level unchanged.
        host_data = 8'hC3;
        cyc(6);
        strobe = 1'b0;
        cyc(2);
        check("t5.head", rx_data, rxq[0]);
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
        cyc(4);
        strobe = 1'b1;
        cyc(6);
        void'(rxq.pop_front());
        rxq.push_back(8'hC3);
        check_state("t5");
        while (rxq.size() != 0) rx_pop("t5.drain");

        // TX reads then underrun.
        tx_push(8'hA5);
        tx_push(8'h5A);
        host_read("t3.r0");
        host_read("t3.r1");
        host_read("t3.r2");
        check_state("t3");

        // Direction toggles without strobes.
        set_cs(1'b1);
        host_drive = 1'b0;
        chip_select = 1'b0;
        cyc(2);
        check("t4.drive_lag", bus_drive, 0);
        cyc(1);
        check("t4.drive_on", bus_drive, 1);
        check("t4.pins", data_pins, m_out);
        chip_select = 1'b1;
        cyc(2);
        check("t4.release_lag", bus_drive, 1);
        cyc(1);
        check("t4.release", bus_drive, 0);
        cyc(4);
        host_drive = 1'b1;
        check_state("t4");

        // Random traffic.
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 4))
                0, 1: host_write(8'($urandom));
                2: host_read("rnd.read");
                3: tx_push(8'($urandom));
                default: if (rxq.size() != 0) rx_pop("rnd.pop"); else clear_pulse();
            endcase
            check_state("rnd");
        end

        // Reset in the middle of a read burst.
        for (int i = 0; i < 4; i++) tx_push(8'($urandom));
        host_read("t6.r0");
        host_write(8'h44);
        host_read("t6.r1");
        strobe = 1'b0;
        cyc(2);
        #3 reset_n = 1'b0;
        #1;
        check("t6.bus_drive", bus_drive, 0);
        rxq.delete();
        txq.delete();
        m_ovf = 1'b0;
        m_und = 1'b0;
        m_out = 8'h00;
        check_state("t6");
        strobe = 1'b1;
        chip_select = 1'b1;
        cyc(3);
        reset_n = 1'b1;
        cyc(8);
        host_drive = 1'b1;
        host_write(8'h5C);
        check_state("t6.after");
        rx_pop("t6.pop");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
